sipo_rx_reg: RTL

//   Serial-in/parallel-out receive register: the far end of the PISO serial link.

---
 rtl/sipo_pkg.sv | 16 +
 rtl/sipo_rx_reg_if.sv | 44 ++++
 rtl/sipo_bit_counter.sv | 30 +++
 rtl/sipo_rx_reg.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// sipo_rx_reg shared types: FSM state encoding and counter width helper.
// Used by the top, the bit counter and the bench.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } sipo_state_t;

  // Width wide enough to hold values 0..width.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_rx_reg_if.sv
// sipo_rx_reg bus: serial input side plus parallel valid/ready output side.
// parity_err exists only when PARITY_CHECK_EN is defined.
interface sipo_rx_reg_if #(
  parameter int WIDTH = 4
);

  logic             serial_in;
  logic             shift_en;
  logic [WIDTH-1:0] D_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;
`ifdef PARITY_CHECK_EN
  logic             parity_err;
`endif

  modport master (
    output serial_in,
    output shift_en,
    output out_ready,
    input  D_out,
    input  out_valid,
    input  busy,
    input  overrun
`ifdef PARITY_CHECK_EN
    , input parity_err
`endif
  );

  modport slave (
    input  serial_in,
    input  shift_en,
    input  out_ready,
    output D_out,
    output out_valid,
    output busy,
    output overrun
`ifdef PARITY_CHECK_EN
    , output parity_err
`endif
  );

endinterface

// File: rtl/sipo_bit_counter.sv
// sipo_bit_counter: counts accepted data bits of the current word.
// last flags the increment that completes the word.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = cnt_w(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          last
);

  assign last = (count == CW'(WIDTH - 1)) & inc;

  // Bit position register; clr wins so the wrap lands on the completion edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/sipo_rx_reg.sv
// sipo_rx_reg: serial-in/parallel-out receiver with valid/ready output.
// Optional even-parity check per word: define PARITY_CHECK_EN.
module sipo_rx_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  sipo_rx_reg_if.slave      bus
);

  localparam int CW = cnt_w(WIDTH);

  sipo_state_t      r_state;
  sipo_state_t      w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] w_word;
  logic             r_valid;
  logic             r_overrun;
  logic [CW-1:0]    w_count;
  logic             w_inc;
  logic             w_last;
  logic             w_done;
  logic             w_take;
  logic             w_busy;
`ifdef PARITY_CHECK_EN
  logic             r_perr;
  logic             w_perr;
`endif

  sipo_bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_inc),
    .clr   (w_last),
    .count (w_count),
    .last  (w_last)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: a word ends on the bit sampled at count WIDTH-1.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.shift_en) begin
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.shift_en && (w_count == CW'(WIDTH - 1))) begin
`ifdef PARITY_CHECK_EN
          w_state_nxt = PARITY;
`else
          w_state_nxt = IDLE;
`endif
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (bus.shift_en) begin
          w_state_nxt = IDLE;
        end
      end
`endif
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM outputs: data bits are taken in IDLE and SHIFT only.
  always_comb begin
    w_inc  = 1'b0;
    w_busy = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_inc = bus.shift_en;
      end
      SHIFT: begin
        w_inc  = bus.shift_en;
        w_busy = 1'b1;
      end
      default: begin
        w_busy = 1'b1;
      end
    endcase
  end

  // Next shift value, ordered so the first bit ends at the chosen end.
  always_comb begin
    w_shift_nxt = r_shift;
    if (w_inc) begin
      if (MSB_FIRST != 0) begin
        w_shift_nxt = {r_shift[WIDTH-2:0], bus.serial_in};
      end else begin
        w_shift_nxt = {bus.serial_in, r_shift[WIDTH-1:1]};
      end
    end
  end

  // Shift register; holds whenever no data bit is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
    end else begin
      r_shift <= w_shift_nxt;
    end
  end

`ifdef PARITY_CHECK_EN
  assign w_done = (r_state == PARITY) & bus.shift_en;
  assign w_word = r_shift;
  assign w_perr = ^{r_shift, bus.serial_in};
`else
  assign w_done = w_last;
  assign w_word = w_shift_nxt;
`endif

  // A finished word is taken if the slot is free or being emptied now.
  assign w_take = w_done & (~r_valid | bus.out_ready);

  // Output word, valid flag and sticky overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_take) begin
        r_dout  <= w_word;
        r_valid <= 1'b1;
      end else if (bus.out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_done && !w_take) begin
        r_overrun <= 1'b1;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  // Parity status tracks the word currently held in D_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perr <= 1'b0;
    end else if (w_take) begin
      r_perr <= w_perr;
    end
  end

  assign bus.parity_err = r_perr;
`endif

  assign bus.D_out     = r_dout;
  assign bus.out_valid = r_valid;
  assign bus.busy      = w_busy;
  assign bus.overrun   = r_overrun;

endmodule
